// File: rtl/lz4_pkg.sv
// Shared constants, state encoding and lookup helpers for the LZ4 frame parser.
package lz4_pkg;

  localparam logic [31:0] Lz4Magic = 32'h184D2204;

  typedef enum logic [3:0] {
    StMagic,
    StFlg,
    StBd,
    StOpt,
    StHc,
    StBsize,
    StBdata,
    StBcsum,
    StCcsum,
    StDone,
    StError
  } lz4_state_e;

  localparam logic [2:0] ErrNone  = 3'd0;
  localparam logic [2:0] ErrMagic = 3'd1;
  localparam logic [2:0] ErrFlg   = 3'd2;
  localparam logic [2:0] ErrBd    = 3'd3;
  localparam logic [2:0] ErrBsize = 3'd4;

  localparam int unsigned FlgBChk  = 4;
  localparam int unsigned FlgCSize = 3;
  localparam int unsigned FlgCChk  = 2;
  localparam int unsigned FlgDict  = 0;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [31:0] m;
    m = Lz4Magic;
    return m[{idx, 3'b000} +: 8];
  endfunction

  // Block maximum is 1 << (2*id + 8); ids below 4 are rejected earlier.
  function automatic logic [30:0] block_max(input logic [2:0] id);
    logic [30:0] m;
    case (id)
      3'd4:    m = 31'h0001_0000;
      3'd5:    m = 31'h0004_0000;
      3'd6:    m = 31'h0010_0000;
      3'd7:    m = 31'h0040_0000;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lz4_le_field_collector.sv
// Counts the bytes of a fixed-length field and assembles its first four bytes
// as a little-endian word; word_o already includes the byte on byte_i.
module lz4_le_field_collector (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        advance_i,
  input  logic [3:0]  len_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  pos_o,
  output logic [31:0] word_o,
  output logic        last_o
);

  logic [3:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    word_o = word_q;
    if (idx_q < 4'd4) begin
      word_o[{idx_q[1:0], 3'b000} +: 8] = byte_i;
    end
    last_o = (idx_q == len_i - 4'd1);
    idx_d  = idx_q;
    word_d = word_q;
    if (advance_i) begin
      idx_d  = last_o ? 4'd0 : idx_q + 4'd1;
      word_d = last_o ? 32'd0 : word_o;
    end
  end

  assign pos_o = idx_q[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/lz4_frame_parser.sv
// Strips LZ4 frame framing and forwards compressed-block payload to the
// decompressor; stored blocks go to the bypass port, checksums are skipped.
module lz4_frame_parser
  import lz4_pkg::*;
#(
  parameter int unsigned word_size  = 8,
  parameter int unsigned size_width = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [word_size-1:0] in_byte,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [word_size-1:0] compressed_word,
  output logic                 write,
  output logic [word_size-1:0] bypass_word,
  output logic                 bypass_valid,
  output logic                 block_start,
  output logic                 frame_done,
  output logic                 error,
  output logic [2:0]           error_code
);

  lz4_state_e state_q, state_d;
  logic bchk_q, bchk_d, csize_q, csize_d, cchk_q, cchk_d, dict_q, dict_d;
  logic [2:0] bd_id_q, bd_id_d;
  logic stored_q, stored_d;
  logic [size_width-1:0] remain_q, remain_d;
  logic [word_size-1:0] cw_q, cw_d, bw_q, bw_d;
  logic write_q, write_d, bv_q, bv_d, bstart_q, bstart_d, fdone_q, fdone_d;
  logic err_q, err_d;
  logic [2:0] code_q, code_d;

  logic        acc;
  logic        fld_adv, fld_last;
  logic [3:0]  fld_len;
  logic [1:0]  fld_pos;
  logic [31:0] fld_word;
  logic [30:0] blk_size;

  assign in_ready = (state_q != StError);
  assign acc      = in_valid && in_ready;
  assign blk_size = fld_word[30:0];

  always_comb begin
    fld_len = 4'd4;
    fld_adv = 1'b0;
    case (state_q)
      StMagic, StDone, StBsize, StBcsum, StCcsum: fld_adv = acc;
      StOpt: begin
        fld_adv = acc;
        fld_len = csize_q ? (dict_q ? 4'd12 : 4'd8) : 4'd4;
      end
      StHc: begin
        fld_adv = acc;
        fld_len = 4'd1;
      end
      default: ;
    endcase
  end

  lz4_le_field_collector u_field (
    .clk_i     (clk),
    .rst_ni    (reset),
    .advance_i (fld_adv),
    .len_i     (fld_len),
    .byte_i    (in_byte),
    .pos_o     (fld_pos),
    .word_o    (fld_word),
    .last_o    (fld_last)
  );

  always_comb begin
    state_d  = state_q;
    bchk_d   = bchk_q;
    csize_d  = csize_q;
    cchk_d   = cchk_q;
    dict_d   = dict_q;
    bd_id_d  = bd_id_q;
    stored_d = stored_q;
    remain_d = remain_q;
    cw_d     = cw_q;
    bw_d     = bw_q;
    write_d  = 1'b0;
    bv_d     = 1'b0;
    bstart_d = 1'b0;
    fdone_d  = 1'b0;
    err_d    = err_q;
    code_d   = code_q;

    case (state_q)
      // Done doubles as magic byte 0 so concatenated frames need no gap cycle.
      StMagic, StDone: begin
        if (state_q == StDone) state_d = StMagic;
        if (acc) begin
          if (in_byte != magic_byte(fld_pos)) begin
            state_d = StError;
            err_d   = 1'b1;
            code_d  = ErrMagic;
          end else if (fld_last) begin
            state_d = StFlg;
          end
        end
      end
      StFlg: if (acc) begin
        if (in_byte[7:6] != 2'b01 || in_byte[1]) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = ErrFlg;
        end else begin
          bchk_d  = in_byte[FlgBChk];
          csize_d = in_byte[FlgCSize];
          cchk_d  = in_byte[FlgCChk];
          dict_d  = in_byte[FlgDict];
          state_d = StBd;
        end
      end
      StBd: if (acc) begin
        if (in_byte[7] || in_byte[3:0] != 4'd0 || in_byte[6:4] < 3'd4) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = ErrBd;
        end else begin
          bd_id_d = in_byte[6:4];
          state_d = (csize_q || dict_q) ? StOpt : StHc;
        end
      end
      StOpt: if (acc && fld_last) state_d = StHc;
      StHc:  if (acc) state_d = StBsize;
      StBsize: if (acc && fld_last) begin
        if (blk_size == 31'd0) begin
          state_d = cchk_q ? StCcsum : StDone;
          fdone_d = !cchk_q;
        end else if (blk_size > block_max(bd_id_q)) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = ErrBsize;
        end else begin
          stored_d = fld_word[31];
          remain_d = blk_size[size_width-1:0];
          bstart_d = 1'b1;
          state_d  = StBdata;
        end
      end
      StBdata: if (acc) begin
        if (stored_q) begin
          bw_d = in_byte;
          bv_d = 1'b1;
        end else begin
          cw_d    = in_byte;
          write_d = 1'b1;
        end
        remain_d = remain_q - size_width'(1);
        if (remain_q == size_width'(1)) state_d = bchk_q ? StBcsum : StBsize;
      end
      StBcsum: if (acc && fld_last) state_d = StBsize;
      StCcsum: if (acc && fld_last) begin
        state_d = StDone;
        fdone_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StMagic;
      bchk_q   <= 1'b0;
      csize_q  <= 1'b0;
      cchk_q   <= 1'b0;
      dict_q   <= 1'b0;
      bd_id_q  <= '0;
      stored_q <= 1'b0;
      remain_q <= '0;
      cw_q     <= '0;
      bw_q     <= '0;
      write_q  <= 1'b0;
      bv_q     <= 1'b0;
      bstart_q <= 1'b0;
      fdone_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ErrNone;
    end else begin
      state_q  <= state_d;
      bchk_q   <= bchk_d;
      csize_q  <= csize_d;
      cchk_q   <= cchk_d;
      dict_q   <= dict_d;
      bd_id_q  <= bd_id_d;
      stored_q <= stored_d;
      remain_q <= remain_d;
      cw_q     <= cw_d;
      bw_q     <= bw_d;
      write_q  <= write_d;
      bv_q     <= bv_d;
      bstart_q <= bstart_d;
      fdone_q  <= fdone_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign compressed_word = cw_q;
  assign write           = write_q;
  assign bypass_word     = bw_q;
  assign bypass_valid    = bv_q;
  assign block_start     = bstart_q;
  assign frame_done      = fdone_q;
  assign error           = err_q;
  assign error_code      = code_q;

endmodule

// File: tb/tb_lz4_frame_parser.sv
// Scoreboard bench for lz4_frame_parser: payload bytes are queued as they are
// driven and checked in order as write/bypass strobes appear.
module tb_lz4_frame_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] compressed_word;
  logic       write;
  logic [7:0] bypass_word;
  logic       bypass_valid;
  logic       block_start;
  logic       frame_done;
  logic       error;
  logic [2:0] error_code;

  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0, bv_cnt = 0, bs_cnt = 0, fd_cnt = 0;
  logic [7:0] exp_wr[$];
  logic [7:0] exp_bv[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  lz4_frame_parser #(
    .word_size  (8),
    .size_width (23)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_byte         (in_byte),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .compressed_word (compressed_word),
    .write           (write),
    .bypass_word     (bypass_word),
    .bypass_valid    (bypass_valid),
    .block_start     (block_start),
    .frame_done      (frame_done),
    .error           (error),
    .error_code      (error_code)
  );

  // Scoreboard: strobes are sampled on the falling edge.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      wr_cnt++;
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: write with %h, expected no write", compressed_word);
      end else begin
        mon_exp = exp_wr.pop_front();
        if (compressed_word !== mon_exp) begin
          n_fail++;
          $display("FAIL write_data: got %h, expected %h", compressed_word, mon_exp);
        end
      end
    end
    if (bypass_valid === 1'b1) begin
      bv_cnt++;
      n_checks++;
      if (exp_bv.size() == 0) begin
        n_fail++;
        $display("FAIL bypass_unexpected: bypass with %h, expected none", bypass_word);
      end else begin
        mon_exp = exp_bv.pop_front();
        if (bypass_word !== mon_exp) begin
          n_fail++;
          $display("FAIL bypass_data: got %h, expected %h", bypass_word, mon_exp);
        end
      end
    end
    if (block_start === 1'b1) bs_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pl(input logic [7:0] b, input bit stored);
    if (stored) exp_bv.push_back(b);
    else exp_wr.push_back(b);
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send_hdr(input logic [7:0] flg, input logic [7:0] bd);
    send(8'h04); send(8'h22); send(8'h4D); send(8'h18);
    send(flg); send(bd); send(8'hC0);
  endtask

  task automatic send_block(input int n, input logic [7:0] base, input logic [7:0] step);
    send(8'(n)); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < n; i++) send_pl(8'(base + 8'(i) * step), 1'b0);
  endtask

  task automatic send_end();
    repeat (4) send(8'h00);
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    do_reset();
    obs = {write, bypass_valid, block_start, frame_done, error, in_ready, error_code,
           compressed_word, bypass_word};
    n_checks++;
    if (obs !== {5'b00000, 1'b1, 3'd0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_values: got %h, expected %h", obs, {5'b00000, 1'b1, 19'd0});
    end
  endtask

  task automatic test_minimal();
    int wr0 = wr_cnt, bs0 = bs_cnt, fd0 = fd_cnt;
    send_hdr(8'h40, 8'h40);
    send_block(5, 8'h11, 8'h11);
    send_end();
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL min_frame_done_latency: got %b, expected 1", frame_done);
    end
    idle(3);
    n_checks++;
    if (wr_cnt - wr0 != 5) begin
      n_fail++;
      $display("FAIL min_write_count: got %0d, expected 5", wr_cnt - wr0);
    end
    n_checks++;
    if (bs_cnt - bs0 != 1 || fd_cnt - fd0 != 1) begin
      n_fail++;
      $display("FAIL min_pulses: block_start %0d frame_done %0d, expected 1 and 1",
               bs_cnt - bs0, fd_cnt - fd0);
    end
    n_checks++;
    if (error !== 1'b0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL min_error_or_missing: error %b pending %0d, expected 0 and 0",
               error, exp_wr.size());
    end
  endtask

  task automatic test_checksums();
    int wr0 = wr_cnt, bs0 = bs_cnt, fd0 = fd_cnt;
    send(8'h04); send(8'h22); send(8'h4D); send(8'h18);
    send(8'h5C); send(8'h40);
    repeat (8) send(8'hC5);
    send(8'h99);
    send_block(3, 8'h01, 8'h01);
    repeat (4) send(8'hEE);
    send_block(3, 8'h04, 8'h01);
    repeat (4) send(8'hEE);
    send_end();
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL ck_early_done: got %b before content checksum, expected 0", frame_done);
    end
    repeat (4) send(8'hCC);
    idle(3);
    n_checks++;
    if (wr_cnt - wr0 != 6 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL ck_write_count: got %0d pending %0d, expected 6 and 0",
               wr_cnt - wr0, exp_wr.size());
    end
    n_checks++;
    if (bs_cnt - bs0 != 2 || fd_cnt - fd0 != 1 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL ck_pulses: block_start %0d frame_done %0d error %b, expected 2 1 0",
               bs_cnt - bs0, fd_cnt - fd0, error);
    end
  endtask

  task automatic test_stored();
    int wr0 = wr_cnt, bv0 = bv_cnt, fd0 = fd_cnt;
    send_hdr(8'h40, 8'h40);
    send(8'h02); idle(2); send(8'h00); send(8'h00); send(8'h80);
    send_pl(8'hAA, 1'b1);
    idle(3);
    send_pl(8'hBB, 1'b1);
    idle(2);
    send_end();
    idle(2);
    n_checks++;
    if (bv_cnt - bv0 != 2 || exp_bv.size() != 0) begin
      n_fail++;
      $display("FAIL stored_bypass_count: got %0d pending %0d, expected 2 and 0",
               bv_cnt - bv0, exp_bv.size());
    end
    n_checks++;
    if (wr_cnt - wr0 != 0 || fd_cnt - fd0 != 1) begin
      n_fail++;
      $display("FAIL stored_write_or_done: write %0d frame_done %0d, expected 0 and 1",
               wr_cnt - wr0, fd_cnt - fd0);
    end
  endtask

  task automatic test_errors();
    logic [7:0] flg_t[5] = '{8'h80, 8'h42, 8'h40, 8'h40, 8'h40};
    logic [7:0] bd_t[5]  = '{8'h40, 8'h40, 8'h30, 8'h41, 8'hC0};
    logic [2:0] code_t[5] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd3};
    int wr0;
    do_reset();
    send(8'h04); send(8'h22); send(8'h4D); send(8'h19);
    n_checks++;
    if (error !== 1'b1 || error_code !== 3'd1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_magic: error %b code %0d in_ready %b, expected 1 1 0",
               error, error_code, in_ready);
    end
    wr0 = wr_cnt;
    send(8'h04); send(8'h22); send(8'h4D); send(8'h18); send(8'h40); send(8'h40);
    idle(2);
    n_checks++;
    if (error !== 1'b1 || error_code !== 3'd1 || wr_cnt != wr0) begin
      n_fail++;
      $display("FAIL error_sticky: error %b code %0d writes %0d, expected 1 1 0",
               error, error_code, wr_cnt - wr0);
    end
    for (int i = 0; i < 5; i++) begin
      do_reset();
      send(8'h04); send(8'h22); send(8'h4D); send(8'h18);
      send(flg_t[i]); send(bd_t[i]);
      n_checks++;
      if (error !== 1'b1 || error_code !== code_t[i]) begin
        n_fail++;
        $display("FAIL hdr_error_%0d: error %b code %0d, expected 1 %0d",
                 i, error, error_code, code_t[i]);
      end
    end
  endtask

  task automatic test_block_max();
    do_reset();
    send_hdr(8'h40, 8'h40);
    send(8'h01); send(8'h00); send(8'h01); send(8'h00);
    n_checks++;
    if (error !== 1'b1 || error_code !== 3'd4 || block_start !== 1'b0) begin
      n_fail++;
      $display("FAIL bsize_over: error %b code %0d block_start %b, expected 1 4 0",
               error, error_code, block_start);
    end
    do_reset();
    send_hdr(8'h40, 8'h40);
    send(8'h00); send(8'h00); send(8'h01); send(8'h00);
    n_checks++;
    if (error !== 1'b0 || block_start !== 1'b1) begin
      n_fail++;
      $display("FAIL bsize_max: error %b block_start %b, expected 0 1", error, block_start);
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] obs;
    int wr0, bs0, fd0;
    do_reset();
    wr0 = wr_cnt;
    send_hdr(8'h40, 8'h40);
    send(8'h05); send(8'h00); send(8'h00); send(8'h00);
    send_pl(8'hA1, 1'b0);
    send_pl(8'hA2, 1'b0);
    do_reset();
    obs = {write, bypass_valid, block_start, frame_done, error, in_ready, error_code,
           compressed_word, bypass_word};
    n_checks++;
    if (obs !== {5'b00000, 1'b1, 3'd0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL midblock_reset: got %h, expected %h", obs, {5'b00000, 1'b1, 19'd0});
    end
    idle(4);
    n_checks++;
    if (wr_cnt - wr0 != 2 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL midblock_strobes: got %0d pending %0d, expected 2 and 0",
               wr_cnt - wr0, exp_wr.size());
    end
    wr0 = wr_cnt; bs0 = bs_cnt; fd0 = fd_cnt;
    send_hdr(8'h40, 8'h40);
    send_block(5, 8'h30, 8'h03);
    send_end();
    send_hdr(8'h40, 8'h40);
    send_block(4, 8'h70, 8'h05);
    send_end();
    idle(3);
    n_checks++;
    if (fd_cnt - fd0 != 2 || bs_cnt - bs0 != 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: frame_done %0d block_start %0d, expected 2 and 2",
               fd_cnt - fd0, bs_cnt - bs0);
    end
    n_checks++;
    if (wr_cnt - wr0 != 9 || exp_wr.size() != 0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_writes: got %0d pending %0d error %b, expected 9 0 0",
               wr_cnt - wr0, exp_wr.size(), error);
    end
  endtask

  initial begin
    test_reset();
    test_minimal();
    test_checksums();
    test_stored();
    test_errors();
    test_block_max();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
